// File: rtl/mem_wb_pkg.sv
// Shared types for the parametrised Wishbone memory slave.
package mem_wb_pkg;
  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int WAIT_W = 4;
endpackage

// File: rtl/mem_wb_ram.sv
// Word array with byte-enabled synchronous write and synchronous read; no reset on storage.
module mem_wb_ram #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/mem_wb_param.sv
// Wishbone-classic memory slave: init sweep, wait states, byte-lane writes,
// out-of-range error termination and cycle abort.
module mem_wb_param
  import mem_wb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [7:0]  INIT_BYTE   = 8'h11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc,
  input  logic                strb,
  input  logic                we,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                busy
);
  localparam int                NB        = DATA_W / 8;
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] INIT_WORD = {NB{INIT_BYTE}};
  localparam logic [IDX_W-1:0]  LAST      = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("mem_wb_param: DATA_W must be a multiple of 8 and at least 8");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("mem_wb_param: DEPTH must be in 1..2**ADDR_W");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_wb_param: WAIT_CYCLES must be in 0..15");
  end

  state_t              state, state_d;
  logic [IDX_W-1:0]    ptr;
  logic [WAIT_W-1:0]   cnt;
  logic                rd_vld;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [NB-1:0]       sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req, in_range;
  logic                ram_en, ram_we;
  logic [NB-1:0]       ram_be;
  logic [IDX_W-1:0]    ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;

  assign req      = cyc && strb;
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign busy     = (state == INIT);
  // The RAM read register is not reset, so it is exposed only in the ack cycle of a read.
  assign rdata    = rd_vld ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = addr_q[IDX_W-1:0];
    ram_wdata = wdata_q;
    case (state)
      INIT: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_be    = '1;
        ram_addr  = ptr;
        ram_wdata = INIT_WORD;
        if (ptr == LAST) state_d = IDLE;
      end
      IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!cyc)           state_d = IDLE;
        else if (cnt == '0) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        ram_en  = in_range;
        ram_we  = we_q;
        ram_be  = sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      cnt    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      rd_vld <= 1'b0;
    end else begin
      ack    <= 1'b0;
      err    <= 1'b0;
      rd_vld <= 1'b0;
      case (state)
        INIT: if (ptr != LAST) ptr <= ptr + 1'b1;
        IDLE: if (req) cnt <= WAIT_LOAD;
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        RESP: begin
          ack    <= in_range;
          err    <= !in_range;
          rd_vld <= in_range && !we_q;
        end
        default: ;
      endcase
    end
  end

  // Request latch: data only, held from acceptance until the response edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q  <= addr;
      we_q    <= we;
      sel_q   <= sel;
      wdata_q <= wdata;
    end
  end

  mem_wb_ram #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_mem_wb_param.sv
// Bench for mem_wb_param: directed and random bus transactions against a word-array model.
module tb_mem_wb_param;
  localparam int W = 3;
  localparam int D = 16;
  localparam logic [31:0] IW = 32'h11111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, strb, we;
  logic [3:0]  sel;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack, err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [D];

  always #5 clk = ~clk;

  mem_wb_param #(
    .DATA_W      (32),
    .ADDR_W      (8),
    .DEPTH       (D),
    .WAIT_CYCLES (W),
    .INIT_BYTE   (8'h11)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cyc   (cyc),
    .strb  (strb),
    .we    (we),
    .sel   (sel),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) model[i] = IW;
  endtask

  // Count cycles of busy from the current negedge until it drops.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(D));
  endtask

  // One complete bus cycle, started on a negedge with the slave idle.
  task automatic txn(input logic w, input logic [7:0] a, input logic [3:0] s,
                     input logic [31:0] d, input string tag, output logic [31:0] rd_obs);
    int n;
    logic both, exp_err;
    logic [31:0] exp_rd;
    exp_err = (int'(a) >= D);
    exp_rd  = (!exp_err && !w) ? model[a[3:0]] : 32'h0;
    cyc = 1'b1; strb = 1'b1; we = w; sel = s; addr = a; wdata = d;
    n = 0; both = 1'b0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
      if (ack && err) both = 1'b1;
    end while (!(ack || err) && n < 40);
    rd_obs = rdata;
    check({tag, "/latency"}, 32'(n), 32'(W + 2));
    check({tag, "/ack"}, {31'b0, ack}, {31'b0, !exp_err});
    check({tag, "/err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "/rdata"}, rdata, exp_rd);
    check({tag, "/ack_and_err"}, {31'b0, both}, 32'h0);
    cyc = 1'b0; strb = 1'b0; we = 1'b0;
    if (w && !exp_err)
      for (int i = 0; i < 4; i++)
        if (s[i]) model[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
    @(negedge clk);
    check({tag, "/pulse_end"}, {30'b0, ack, err}, 32'h0);
    check({tag, "/rdata_end"}, rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        seen;
    int          t;
    int          acks[$];
    logic [7:0]  ra;
    logic        rw;
    logic [3:0]  rs;
    logic [31:0] rdat;

    rst = 1'b0; cyc = 1'b0; strb = 1'b0; we = 1'b0;
    sel = '0; addr = '0; wdata = '0;
    #1;
    check("reset/busy", {31'b0, busy}, 32'h1);
    check("reset/ack_err", {30'b0, ack, err}, 32'h0);
    check("reset/rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    count_busy("init/busy_cycles");
    model_reset();

    txn(1'b0, 8'd5, 4'h0, 32'h0, "rd5", rd);
    check("rd5/init_value", rd, 32'h11111111);

    txn(1'b1, 8'd3, 4'b0101, 32'hAABBCCDD, "wr3", rd);
    txn(1'b0, 8'd3, 4'h0, 32'h0, "rd3", rd);
    check("rd3/merged", rd, 32'h11BB11DD);

    txn(1'b0, 8'd20, 4'hF, 32'h0, "rd20_oor", rd);
    txn(1'b1, 8'd20, 4'hF, 32'h12345678, "wr20_oor", rd);
    for (int i = 0; i < D; i++) txn(1'b0, 8'(i), 4'h0, 32'h0, "sweep", rd);

    // Back-to-back reads with the request held continuously.
    cyc = 1'b1; strb = 1'b1; we = 1'b0; addr = 8'd5; sel = 4'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) begin
        acks.push_back(i);
        check("b2b/rdata", rdata, model[5]);
      end
    end
    cyc = 1'b0; strb = 1'b0;
    check("b2b/count", 32'(acks.size()), 32'd4);
    check("b2b/first", 32'(acks[0]), 32'(W + 2));
    for (int i = 1; i < acks.size(); i++)
      check("b2b/spacing", 32'(acks[i] - acks[i-1]), 32'(W + 2));
    @(negedge clk);

    // Abort: cyc dropped while waiting.
    cyc = 1'b1; strb = 1'b1; we = 1'b1; addr = 8'd1; sel = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    cyc = 1'b0; strb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack || err) seen = 1'b1;
    end
    check("abort/no_response", {31'b0, seen}, 32'h0);
    txn(1'b0, 8'd1, 4'h0, 32'h0, "abort_rd1", rd);
    check("abort_rd1/unchanged", rd, 32'h11111111);

    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom_range(0, 19));
      rw   = 1'($urandom_range(0, 1));
      rs   = 4'($urandom_range(0, 15));
      rdat = $urandom;
      txn(rw, ra, rs, rdat, "rnd", rd);
    end
    for (int i = 0; i < D; i++) txn(1'b0, 8'(i), 4'h0, 32'h0, "rnd_sweep", rd);

    // Reset asserted while a write sits in its wait states.
    cyc = 1'b1; strb = 1'b1; we = 1'b1; addr = 8'd7; sel = 4'hF; wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid/ack_err", {30'b0, ack, err}, 32'h0);
    check("rst_mid/rdata", rdata, 32'h0);
    check("rst_mid/busy", {31'b0, busy}, 32'h1);
    cyc = 1'b0; strb = 1'b0; we = 1'b0;
    @(negedge clk); @(negedge clk);
    t = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack || err || !busy) t++;
    end
    check("rst_hold/quiet", 32'(t), 32'h0);
    rst = 1'b1;
    count_busy("reinit/busy_cycles");
    model_reset();
    txn(1'b0, 8'd7, 4'h0, 32'h0, "rst_rd7", rd);
    check("rst_rd7/init_value", rd, 32'h11111111);
    txn(1'b0, 8'd3, 4'h0, 32'h0, "rst_rd3", rd);
    check("rst_rd3/init_value", rd, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
